// File: rtl/sfx_engine.sv
// Square-wave sound effect engine: background siren sweep plus prioritised
// one-shot effects (chomp, death, beep) with pause-freeze and stall-mute.
module sfx_engine #(
   parameter int TONE_W      = 23,
   parameter int DIV_W       = 15,
   parameter int RAMP_W      = 7,
   parameter int DUR_W       = 24,
   parameter int CHOMP_LEN   = 2500000,
   parameter int DEATH_LEN   = 12500000,
   parameter int BEEP_LEN    = 1250000,
   parameter int CHOMP_DIV_A = 12000,
   parameter int CHOMP_DIV_B = 9000,
   parameter int CHOMP_BIT   = 19,
   parameter int DEATH_BASE  = 6000,
   parameter int DEATH_SHIFT = 10,
   parameter int BEEP_DIV    = 4000
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       pause,
   input  logic       stall,
   input  logic       siren_en,
   input  logic       trig,
   input  logic [1:0] sfx_sel,
   output logic       speaker,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, SIREN, CHOMP, DEATH, BEEP} state_t;

   localparam int SUM_W = DUR_W + DIV_W + 1;
   localparam logic [DUR_W-1:0] CHOMP_LAST = DUR_W'(CHOMP_LEN - 1);
   localparam logic [DUR_W-1:0] DEATH_LAST = DUR_W'(DEATH_LEN - 1);
   localparam logic [DUR_W-1:0] BEEP_LAST  = DUR_W'(BEEP_LEN - 1);

   state_t              state, state_nxt, base_st, req_st;
   logic [TONE_W-1:0]   tone;
   logic [DUR_W-1:0]    elapsed;
   logic [DIV_W-1:0]    divcnt, div;
   logic [RAMP_W-1:0]   ramp;
   logic [SUM_W-1:0]    death_sum;
   logic                shot, finish, restart;

   function automatic logic [1:0] prio(input state_t s);
      case (s)
         DEATH:   prio = 2'd3;
         CHOMP:   prio = 2'd2;
         BEEP:    prio = 2'd1;
         default: prio = 2'd0;
      endcase
   endfunction

   assign shot = state inside {CHOMP, DEATH, BEEP};

   // NOTE: every output of a combinational block is assigned a default first so no latch is inferred.
   always_comb begin
      base_st   = siren_en ? SIREN : IDLE;
      req_st    = BEEP;
      finish    = 1'b0;
      restart   = 1'b0;
      case (sfx_sel)
         2'd1:    req_st = CHOMP;
         2'd2:    req_st = DEATH;
         default: req_st = BEEP;
      endcase
      case (state)
         CHOMP:   finish = (elapsed == CHOMP_LAST);
         DEATH:   finish = (elapsed == DEATH_LAST);
         BEEP:    finish = (elapsed == BEEP_LAST);
         default: finish = 1'b0;
      endcase
      state_nxt = (shot && !finish) ? state : base_st;
      if (trig) begin
         if (sfx_sel == 2'd0) begin
            if (shot) state_nxt = base_st;
         end else if (!shot || prio(req_st) >= prio(state)) begin
            state_nxt = req_st;
            restart   = 1'b1;
         end
      end
   end

   // Half-period for the current state; the death glide saturates instead of wrapping.
   always_comb begin
      ramp      = tone[TONE_W-1] ? tone[TONE_W-2 -: RAMP_W] : ~tone[TONE_W-2 -: RAMP_W];
      death_sum = SUM_W'(DEATH_BASE) + SUM_W'(elapsed >> DEATH_SHIFT);
      div       = '0;
      case (state)
         SIREN:   div = DIV_W'({2'b01, ramp}) << (DIV_W - 2 - RAMP_W);
         CHOMP:   div = elapsed[CHOMP_BIT] ? DIV_W'(CHOMP_DIV_B) : DIV_W'(CHOMP_DIV_A);
         DEATH:   div = (death_sum[SUM_W-1:DIV_W] != '0) ? '1 : death_sum[DIV_W-1:0];
         BEEP:    div = DIV_W'(BEEP_DIV);
         default: div = '0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         tone    <= '0;
         elapsed <= '0;
         divcnt  <= '0;
         speaker <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (pause) begin
         speaker <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         busy    <= state_nxt inside {CHOMP, DEATH, BEEP};
         done    <= finish;
         elapsed <= (shot && !restart && state_nxt == state) ? elapsed + 1'b1 : '0;
         if (state == SIREN) tone <= stall ? '0 : tone + 1'b1;
         // Entering a state only clears the divider; the first toggle lands one cycle later.
         if (restart || state_nxt != state) begin
            divcnt <= '0;
         end else if (state == IDLE || (state == SIREN && stall)) begin
            divcnt  <= '0;
            speaker <= 1'b0;
         end else if (divcnt == '0) begin
            divcnt  <= div;
            speaker <= ~speaker;
         end else begin
            divcnt <= divcnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sfx_engine.sv
// Self-checking bench for sfx_engine: directed scenarios and random traffic
// against an arithmetic reference model, plus a default-parameter siren check.
module tb_sfx_engine;

   localparam int TW = 10, DW = 8, RW = 4, UW = 12;
   localparam int CL = 20, DL = 60, BL = 30;
   localparam int CDA = 5, CDB = 3, CB = 2, DB = 245, DS = 2, BD = 4;
   localparam int M_IDLE = 0, M_SIREN = 1, M_CHOMP = 2, M_DEATH = 3, M_BEEP = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, pause = 1'b0, stall = 1'b0, siren_en = 1'b1, trig = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       spk, busy, done;
   logic       rst_a = 1'b1;
   logic       spk_a, busy_a, done_a;

   int n_cmp = 0, n_bad = 0;

   // Reference model state
   int m_mode, m_tone, m_el, m_cnt;
   bit m_spk, m_done;

   sfx_engine #(
      .TONE_W(TW), .DIV_W(DW), .RAMP_W(RW), .DUR_W(UW),
      .CHOMP_LEN(CL), .DEATH_LEN(DL), .BEEP_LEN(BL),
      .CHOMP_DIV_A(CDA), .CHOMP_DIV_B(CDB), .CHOMP_BIT(CB),
      .DEATH_BASE(DB), .DEATH_SHIFT(DS), .BEEP_DIV(BD)
   ) dut (
      .clk(clk), .RST(rst), .pause(pause), .stall(stall), .siren_en(siren_en),
      .trig(trig), .sfx_sel(sel), .speaker(spk), .busy(busy), .done(done)
   );

   sfx_engine dut_a (
      .clk(clk), .RST(rst_a), .pause(1'b0), .stall(1'b0), .siren_en(1'b1),
      .trig(1'b0), .sfx_sel(2'b00), .speaker(spk_a), .busy(busy_a), .done(done_a)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_shot(input int m);
      return m == M_CHOMP || m == M_DEATH || m == M_BEEP;
   endfunction

   function automatic int rank(input int m);
      return (m == M_DEATH) ? 3 : (m == M_CHOMP) ? 2 : (m == M_BEEP) ? 1 : 0;
   endfunction

   function automatic int shot_len(input int m);
      return (m == M_CHOMP) ? CL : (m == M_DEATH) ? DL : BL;
   endfunction

   function automatic int half_period(input int m, input int tn, input int el);
      int seg, ramp;
      case (m)
         M_SIREN: begin
            seg  = (tn / (2 ** (TW - 1 - RW))) % (2 ** RW);
            ramp = (tn >= 2 ** (TW - 1)) ? seg : (2 ** RW - 1) - seg;
            return (2 ** RW + ramp) * (2 ** (DW - 2 - RW));
         end
         M_CHOMP: return ((el / (2 ** CB)) % 2 == 1) ? CDB : CDA;
         M_DEATH: return (DB + el / (2 ** DS) > 2 ** DW - 1) ? 2 ** DW - 1 : DB + el / (2 ** DS);
         M_BEEP:  return BD;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_tone = 0; m_el = 0; m_cnt = 0; m_spk = 0; m_done = 0;
   endtask

   // Advances the model by one clock using the inputs the DUT is about to sample.
   task automatic model_step();
      int base, nxt, req, half;
      bit restart, fin;
      m_done = 0;
      if (pause) begin
         m_spk = 0;
         return;
      end
      base    = siren_en ? M_SIREN : M_IDLE;
      fin     = is_shot(m_mode) && (m_el == shot_len(m_mode) - 1);
      nxt     = (is_shot(m_mode) && !fin) ? m_mode : base;
      restart = 0;
      if (trig) begin
         req = (sel == 2'd1) ? M_CHOMP : (sel == 2'd2) ? M_DEATH : M_BEEP;
         if (sel == 2'd0) begin
            if (is_shot(m_mode)) nxt = base;
         end else if (!is_shot(m_mode) || rank(req) >= rank(m_mode)) begin
            nxt = req;
            restart = 1;
         end
      end
      m_done = fin;
      half = half_period(m_mode, m_tone, m_el);
      if (restart || nxt != m_mode) m_cnt = 0;
      else if (m_mode == M_IDLE || (m_mode == M_SIREN && stall)) begin
         m_cnt = 0; m_spk = 0;
      end else if (m_cnt == 0) begin
         m_cnt = half; m_spk = !m_spk;
      end else m_cnt = m_cnt - 1;
      if (m_mode == M_SIREN) m_tone = stall ? 0 : (m_tone + 1) % (2 ** TW);
      m_el = (is_shot(m_mode) && !restart && nxt == m_mode) ? m_el + 1 : 0;
      m_mode = nxt;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk); #1;
      check("speaker", spk, m_spk);
      check("busy", busy, is_shot(m_mode));
      check("done", done, m_done);
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic fire(input logic [1:0] s);
      trig = 1'b1; sel = s;
      tick();
      trig = 1'b0;
   endtask

   // Counts cycles until done is seen; -1 if the budget runs out.
   task automatic count_to_done(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      model_reset();
      #2;
      check({tag, "_spk"}, spk, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int n, edges_seen;
      int edge_at [3];
      logic prev;

      // Default build: siren right after reset.
      @(posedge clk); #1;
      check("a_rst_spk", spk_a, 0);
      check("a_rst_busy", busy_a, 0);
      rst_a = 1'b0;
      edges_seen = 0;
      edge_at = '{-1, -1, -1};
      prev = spk_a;
      for (int c = 1; c <= 32700; c++) begin
         @(posedge clk); #1;
         if (spk_a !== prev) begin
            if (edges_seen < 3) edge_at[edges_seen] = c;
            edges_seen++;
            prev = spk_a;
         end
      end
      check("a_edges", edges_seen, 3);
      check("a_rise", edge_at[0], 2);
      check("a_fall", edge_at[1], 2 + 16321);
      check("a_rise2", edge_at[2], 2 + 2 * 16321);
      check("a_busy", busy_a, 0);

      // Small build
      do_reset("rst");
      tick_n(150);

      // Chomp from siren, natural completion
      fire(2'd1);
      check("chomp_busy", busy, 1);
      count_to_done(100, n);
      check("chomp_len", n, CL);
      tick();
      check("chomp_idle", busy, 0);
      tick_n(80);

      // Preemption, ignored lower priority, restart; death plays through stall
      fire(2'd1);
      tick_n(5);
      fire(2'd2);
      stall = 1'b1;
      tick_n(3);
      fire(2'd3);
      check("beep_ignored", busy, 1);
      tick_n(2);
      fire(2'd2);
      count_to_done(200, n);
      check("death_len", n, DL);
      tick_n(20);
      check("stall_mute", spk, 0);
      stall = 1'b0;
      tick_n(150);

      // Pause mid-beep delays completion by the pause length
      fire(2'd3);
      tick_n(9);
      pause = 1'b1;
      for (int i = 0; i < 50; i++) begin
         trig = $urandom_range(0, 1);
         sel  = 2'($urandom_range(0, 3));
         tick();
      end
      check("pause_mute", spk, 0);
      pause = 1'b0; trig = 1'b0;
      count_to_done(200, n);
      check("beep_paused_len", 9 + 50 + n, BL + 50);
      tick_n(50);

      // Death glide into saturation, then cancel
      fire(2'd2);
      tick_n(55);
      fire(2'd0);
      check("cancel_done", done, 0);
      check("cancel_busy", busy, 0);
      tick_n(100);

      // Reset in the middle of an effect
      fire(2'd1);
      tick_n(5);
      do_reset("midrst");
      tick_n(20);

      // Random traffic
      for (int i = 0; i < 5000; i++) begin
         trig = ($urandom_range(0, 11) == 0);
         sel  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) pause = ~pause;
         if ($urandom_range(0, 29) == 0) stall = ~stall;
         if ($urandom_range(0, 99) == 0) siren_en = ~siren_en;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
